// File: rtl/el2_pkg.sv
// Shared el2 core types: parameter bundle and DCCM init FSM states.
// Defaults mirror the standard el2_param.vh DCCM configuration.
package el2_pkg;

   typedef struct packed {
      int unsigned DCCM_NUM_BANKS;
      int unsigned DCCM_BITS;
      int unsigned DCCM_BANK_BITS;
      int unsigned DCCM_DATA_WIDTH;
      int unsigned DCCM_FDATA_WIDTH;
   } el2_param_t;

   localparam el2_param_t EL2_PARAM_DEFAULT = '{
      DCCM_NUM_BANKS   : 4,
      DCCM_BITS        : 16,
      DCCM_BANK_BITS   : 2,
      DCCM_DATA_WIDTH  : 32,
      DCCM_FDATA_WIDTH : 39
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      DONE = 2'd2
   } el2_dccm_init_state_e;

endpackage

// File: rtl/el2_dccm_init_ctrl.sv
// DCCM zero-fill sweeper sitting between the LSU DCCM port and the memory.
// While sweeping it owns every bank; otherwise it is a transparent wire.
module el2_dccm_init_ctrl
   import el2_pkg::*;
#(
   parameter el2_param_t pt        = EL2_PARAM_DEFAULT,
   parameter int         AUTO_INIT = 1,
   localparam int NB    = int'(pt.DCCM_NUM_BANKS),
   localparam int A_HI  = int'(pt.DCCM_BITS) - 1,
   localparam int A_LO  = int'(pt.DCCM_BANK_BITS) + 2,
   localparam int DW    = int'(pt.DCCM_DATA_WIDTH),
   localparam int ECC_W = int'(pt.DCCM_FDATA_WIDTH) - int'(pt.DCCM_DATA_WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init_req,
   output logic                init_busy,
   output logic                init_done,
   output logic                init_conflict,

   input  logic [NB-1:0]       core_dccm_clken,
   input  logic [NB-1:0]       core_dccm_wren_bank,
   input  logic [A_HI:A_LO]    core_dccm_addr_bank    [NB],
   input  logic [DW-1:0]       core_dccm_wr_data_bank [NB],
   input  logic [ECC_W-1:0]    core_dccm_wr_ecc_bank  [NB],

   output logic [NB-1:0]       dccm_clken,
   output logic [NB-1:0]       dccm_wren_bank,
   output logic [A_HI:A_LO]    dccm_addr_bank    [NB],
   output logic [DW-1:0]       dccm_wr_data_bank [NB],
   output logic [ECC_W-1:0]    dccm_wr_ecc_bank  [NB]
);

   localparam int ROW_W = int'(pt.DCCM_BITS) - int'(pt.DCCM_BANK_BITS) - 2;
   localparam int DEPTH = 2 ** ROW_W;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH - 1);

   el2_dccm_init_state_e state;
   logic [ROW_W-1:0]     row_cnt;
   logic                 start_pend;
   logic                 start;

   // A sweep begins on the first clock out of reset (auto mode) or on request;
   // both arriving together still produce a single sweep.
   assign start = (state == IDLE && start_pend) || init_req;

   // Sweep FSM, row counter and status flags; busy is a flop so the
   // memory mux never sees a combinational path from the core inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         row_cnt       <= '0;
         start_pend    <= (AUTO_INIT != 0);
         init_busy     <= 1'b0;
         init_done     <= 1'b0;
         init_conflict <= 1'b0;
      end else begin
         start_pend <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= INIT;
                  row_cnt       <= '0;
                  init_busy     <= 1'b1;
                  init_done     <= 1'b0;
                  init_conflict <= 1'b0;
               end
            end
            INIT: begin
               if (|core_dccm_clken) begin
                  init_conflict <= 1'b1;
               end
               if (row_cnt == LAST_ROW) begin
                  state     <= DONE;
                  init_busy <= 1'b0;
                  init_done <= 1'b1;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               init_busy <= 1'b0;
            end
         endcase
      end
   end

   // Memory-side mux: zero-write the current row on every bank while
   // sweeping, otherwise pass the core request straight through.
   always_comb begin
      dccm_clken     = core_dccm_clken;
      dccm_wren_bank = core_dccm_wren_bank;
      for (int b = 0; b < NB; b++) begin
         dccm_addr_bank[b]    = core_dccm_addr_bank[b];
         dccm_wr_data_bank[b] = core_dccm_wr_data_bank[b];
         dccm_wr_ecc_bank[b]  = core_dccm_wr_ecc_bank[b];
      end
      if (init_busy) begin
         dccm_clken     = '1;
         dccm_wren_bank = '1;
         for (int b = 0; b < NB; b++) begin
            dccm_addr_bank[b]    = row_cnt;
            dccm_wr_data_bank[b] = '0;
            dccm_wr_ecc_bank[b]  = '0;
         end
      end
   end

endmodule

// File: tb/tb_el2_dccm_init_ctrl.sv
// Randomized scoreboard bench for the DCCM init controller.
// Two instances: auto-start (0) and request-only (1) share core inputs.
module tb_el2_dccm_init_ctrl;

   localparam int NB    = 4;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int EW    = 7;
   localparam int DEPTH = 4096;

   typedef struct packed {
      logic                   busy;
      logic                   done;
      logic                   conf;
      logic [NB-1:0]          clken;
      logic [NB-1:0]          wren;
      logic [NB-1:0][AW-1:0]  addr;
      logic [NB-1:0][DW-1:0]  data;
      logic [NB-1:0][EW-1:0]  ecc;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t m;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] req = 2'b00;

   logic [NB-1:0] c_clken, c_wren;
   logic [AW-1:0] c_addr [NB];
   logic [DW-1:0] c_data [NB];
   logic [EW-1:0] c_ecc  [NB];

   logic          a_busy, a_done, a_conf;
   logic [NB-1:0] a_clken, a_wren;
   logic [AW-1:0] a_addr [NB];
   logic [DW-1:0] a_data [NB];
   logic [EW-1:0] a_ecc  [NB];

   logic          m_busy, m_done, m_conf;
   logic [NB-1:0] m_clken, m_wren;
   logic [AW-1:0] m_addr [NB];
   logic [DW-1:0] m_data [NB];
   logic [EW-1:0] m_ecc  [NB];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   pair_t sb[$];

   // reference model: rows written in current sweep (-1 = not sweeping)
   int pos  [2];
   bit mdone[2];
   bit mconf[2];
   bit pend [2];

   always #5 clk = ~clk;

   el2_dccm_init_ctrl #(.AUTO_INIT(1)) u_auto (
      .clk(clk), .rst(rst), .init_req(req[0]),
      .init_busy(a_busy), .init_done(a_done), .init_conflict(a_conf),
      .core_dccm_clken(c_clken), .core_dccm_wren_bank(c_wren),
      .core_dccm_addr_bank(c_addr), .core_dccm_wr_data_bank(c_data),
      .core_dccm_wr_ecc_bank(c_ecc),
      .dccm_clken(a_clken), .dccm_wren_bank(a_wren),
      .dccm_addr_bank(a_addr), .dccm_wr_data_bank(a_data),
      .dccm_wr_ecc_bank(a_ecc)
   );

   el2_dccm_init_ctrl #(.AUTO_INIT(0)) u_man (
      .clk(clk), .rst(rst), .init_req(req[1]),
      .init_busy(m_busy), .init_done(m_done), .init_conflict(m_conf),
      .core_dccm_clken(c_clken), .core_dccm_wren_bank(c_wren),
      .core_dccm_addr_bank(c_addr), .core_dccm_wr_data_bank(c_data),
      .core_dccm_wr_ecc_bank(c_ecc),
      .dccm_clken(m_clken), .dccm_wren_bank(m_wren),
      .dccm_addr_bank(m_addr), .dccm_wr_data_bank(m_data),
      .dccm_wr_ecc_bank(m_ecc)
   );

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pos[d]   = -1;
         mdone[d] = 1'b0;
         mconf[d] = 1'b0;
         pend[d]  = (d == 0);
      end
   endtask

   // one rising edge, using the inputs that were stable before it
   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         if (pos[d] >= 0) begin
            if (c_clken != 0) mconf[d] = 1'b1;
            pos[d]++;
            if (pos[d] == DEPTH) begin
               pos[d]   = -1;
               mdone[d] = 1'b1;
            end
         end else if (pend[d] || req[d]) begin
            pos[d]   = 0;
            mdone[d] = 1'b0;
            mconf[d] = 1'b0;
         end
         pend[d] = 1'b0;
      end
   endtask

   function automatic obs_t expect_of(int d);
      obs_t o;
      o.busy = (pos[d] >= 0);
      o.done = mdone[d];
      o.conf = mconf[d];
      if (o.busy) begin
         o.clken = '1;
         o.wren  = '1;
         for (int b = 0; b < NB; b++) begin
            o.addr[b] = AW'(pos[d]);
            o.data[b] = '0;
            o.ecc[b]  = '0;
         end
      end else begin
         o.clken = c_clken;
         o.wren  = c_wren;
         for (int b = 0; b < NB; b++) begin
            o.addr[b] = c_addr[b];
            o.data[b] = c_data[b];
            o.ecc[b]  = c_ecc[b];
         end
      end
      return o;
   endfunction

   task automatic rand_core();
      c_clken = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
      c_wren  = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
         c_addr[b] = AW'($urandom);
         c_data[b] = $urandom;
         c_ecc[b]  = EW'($urandom);
      end
   endtask

   // dir: 0 random, 1 fixed pass-through pattern
   task automatic cycle(input bit n_rst, input bit r0, input bit r1,
                        input int dir);
      pair_t p;
      @(posedge clk);
      model_edge();
      #1;
      rand_core();
      if (dir == 1) begin
         c_clken   = 4'b0010;
         c_addr[1] = 12'h0A5;
      end
      // clken poke at auto sweep row 10 to raise a conflict
      if (pos[0] == 10) c_clken = 4'h1;
      // late requests during the auto sweep must be ignored
      req[0] = r0 || pos[0] == 100 || pos[0] == DEPTH - 1 ||
               (pos[0] >= 0 && $urandom_range(0, 199) == 0);
      req[1] = r1 || (pos[1] >= 0 && $urandom_range(0, 199) == 0);
      if (n_rst && !rst) begin
         rst = 1'b1;
         model_reset();
      end else begin
         rst = n_rst;
      end
      p.a = expect_of(0);
      p.m = expect_of(1);
      sb.push_back(p);
   endtask

   function automatic obs_t pack_obs(
      input logic b, input logic dn, input logic cf,
      input logic [NB-1:0] ck, input logic [NB-1:0] wr,
      input logic [AW-1:0] ad [NB], input logic [DW-1:0] dt [NB],
      input logic [EW-1:0] ec [NB]);
      obs_t o;
      o.busy  = b;
      o.done  = dn;
      o.conf  = cf;
      o.clken = ck;
      o.wren  = wr;
      for (int i = 0; i < NB; i++) begin
         o.addr[i] = ad[i];
         o.data[i] = dt[i];
         o.ecc[i]  = ec[i];
      end
      return o;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp(input string who, input obs_t act, input obs_t exp);
      chk({who, ".busy"}, 256'(act.busy), 256'(exp.busy));
      chk({who, ".done"}, 256'(act.done), 256'(exp.done));
      chk({who, ".conflict"}, 256'(act.conf), 256'(exp.conf));
      chk({who, ".membus"},
          256'({act.clken, act.wren, act.addr, act.data, act.ecc}),
          256'({exp.clken, exp.wren, exp.addr, exp.data, exp.ecc}));
   endtask

   // monitor: compare DUT outputs against the oldest expectation
   always @(negedge clk) begin
      pair_t p;
      cyc++;
      if (sb.size() > 0) begin
         p = sb.pop_front();
         cmp("auto", pack_obs(a_busy, a_done, a_conf, a_clken, a_wren,
                              a_addr, a_data, a_ecc), p.a);
         cmp("man", pack_obs(m_busy, m_done, m_conf, m_clken, m_wren,
                             m_addr, m_data, m_ecc), p.m);
      end
   end

   initial begin
      model_reset();
      rand_core();
      // reset held: both pass through, flags clear
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0);
      // release: auto sweeps, manual waits for a request at step 50
      for (int i = 0; i < 4400; i++) cycle(1'b0, 1'b0, i == 50, 0);
      // both done: pass-through including a fixed pattern
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, (i == 5) ? 1 : 0);
      // restart both from DONE, then reset the auto one mid-sweep
      cycle(1'b0, 1'b1, 1'b1, 0);
      for (int i = 0; i < 2100; i++) begin
         if (pos[0] == 2000) break;
         cycle(1'b0, 1'b0, 1'b0, 0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0);
      // auto re-sweeps from row 0; manual stays idle until asked
      for (int i = 0; i < 4200; i++) cycle(1'b0, 1'b0, i == 300, 0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
